// File: rtl/text_pkg.sv
// Shared constants, state encoding and cursor helper for the text-mode
// character-buffer writers.
package text_pkg;

  localparam int COLS   = 80;   // characters per text row
  localparam int ROWS   = 30;   // text rows on screen
  localparam int LEN_W  = 4;    // ROM address / string length width
  localparam int CHAR_W = 7;    // ASCII code width
  localparam int ADDR_W = 12;   // character-buffer address width
  localparam int CELLS  = ROWS * COLS;

  localparam logic [CHAR_W-1:0] NUL       = 7'h00;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [4:0]        ROW_LIMIT = 5'(ROWS);
  localparam logic [6:0]        COL_LIMIT = 7'(COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Advance the linear cursor by one cell; the last cell of the screen
  // wraps back to the top-left corner.
  function automatic logic [ADDR_W-1:0] next_cell(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] n;
    if (a == LAST_CELL) begin
      n = {ADDR_W{1'b0}};
    end else begin
      n = a + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

endpackage

// File: rtl/text_cell_addr.sv
// Converts a (row, col) screen position into the linear character-buffer
// address row*COLS+col. Purely combinational.
module text_cell_addr
  import text_pkg::*;
(
  input  logic [4:0]        row,
  input  logic [6:0]        col,
  output logic [ADDR_W-1:0] addr
);

  // Linear address of the cell; the result always fits ADDR_W for the
  // full 5-bit row / 7-bit column input range.
  always_comb begin
    addr = (ADDR_W'(row) * ADDR_W'(COLS)) + ADDR_W'(col);
  end

endmodule

// File: rtl/text_string_writer.sv
// Copies a NUL-terminated (or length-limited) string from a combinational
// string ROM into the text-mode character buffer, starting at a requested
// screen cell and wrapping at line and screen end.
module text_string_writer
  import text_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [4:0]        row,
  input  logic [6:0]        col,
  input  logic [LEN_W-1:0]  len,
  output logic [LEN_W-1:0]  rom_addr,
  input  logic [CHAR_W-1:0] rom_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CHAR_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state, state_next;
  logic [LEN_W-1:0]    idx, idx_next;
  logic [LEN_W-1:0]    len_q, len_next;
  logic [ADDR_W-1:0]   lin_addr, lin_next;
  logic [CHAR_W-1:0]   char_q, char_next;
  logic                err_q, err_next;
  logic [ADDR_W-1:0]   start_addr;
  logic                pos_ok;

  text_cell_addr u_cell_addr (
    .row  (row),
    .col  (col),
    .addr (start_addr)
  );

  // Reject requests whose start cell lies off screen.
  always_comb begin
    pos_ok = (row < ROW_LIMIT) && (col < COL_LIMIT);
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      idx      <= {LEN_W{1'b0}};
      len_q    <= {LEN_W{1'b0}};
      lin_addr <= {ADDR_W{1'b0}};
      char_q   <= {CHAR_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      len_q    <= len_next;
      lin_addr <= lin_next;
      char_q   <= char_next;
      err_q    <= err_next;
    end
  end

  // Next-state and datapath update for the fetch/write sequencer.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    len_next   = len_q;
    lin_next   = lin_addr;
    char_next  = char_q;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (pos_ok) begin
            len_next   = len;
            lin_next   = start_addr;
            idx_next   = {LEN_W{1'b0}};
            err_next   = 1'b0;
            state_next = FETCH;
          end else begin
            err_next   = 1'b1;
            state_next = FIN;
          end
        end else begin
          state_next = IDLE;
        end
      end
      FETCH: begin
        // Length limit wins over the ROM contents, so idx never passes len.
        if (idx == len_q) begin
          state_next = FIN;
        end else if (rom_data == NUL) begin
          state_next = FIN;
        end else begin
          char_next  = rom_data;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // Address and data stay registered until the buffer accepts them.
        if (wr_ready) begin
          idx_next   = idx + {{(LEN_W-1){1'b0}}, 1'b1};
          lin_next   = next_cell(lin_addr);
          state_next = FETCH;
        end else begin
          state_next = WRITE;
        end
      end
      FIN: begin
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: begin
        err_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded only from registers; wr_ready never reaches wr_en.
  always_comb begin
    rom_addr = idx;
    wr_addr  = lin_addr;
    wr_data  = char_q;
    wr_en    = (state == WRITE);
    busy     = (state != IDLE);
    done     = (state == FIN);
    err      = (state == FIN) && err_q;
  end

endmodule
